rou_axil_loader: RTL
====================

// Module: rou_axil_loader
// PURPOSE
//  AXI-Lite (BAR1) write slave that loads the per-stage root-of-unity (ROU) tables.
//  Decodes each 32-bit host write into {stage, entry address, half-column}.
//  Drives a one-cycle write strobe broadcast to all per-stage ROU buffers.
//  Each buffer qualifies the strobe with rou_stage; the NTT stages read the buffers downstream.
// PARAMETERS
//  STAGE_NUM    12  number of valid NTT stages; legal stage index 0..STAGE_NUM-1
//  STAGE_W      4   stage-select field width (2**STAGE_W >= STAGE_NUM)
//  ENTRY_ADDR_W 11  ROU buffer word-address width
//  WE_W         16  half-column write-enable width (2*LINE_SIZE); HALF_W = $clog2(WE_W)
//  DATA_W       32  AXI-Lite data width = BIT_WIDTH/2 = one half-column
// PORTS
//  clk            in   1             clock
//  rstn           in   1             async active-low reset
//  s_awaddr       in   32            write address (byte)
//  s_awvalid/s_awready  in/out  1     AW handshake
//  s_wdata        in   DATA_W        write data
//  s_wstrb        in   4             byte strobes
//  s_wvalid/s_wready    in/out  1     W handshake
//  s_bresp        out  2             00 OKAY, 10 SLVERR
//  s_bvalid/s_bready    out/in  1     B handshake
//  s_araddr       in   32            read address (ignored)
//  s_arvalid/s_arready  in/out  1     AR handshake
//  s_rdata        out  DATA_W        write counter
//  s_rresp        out  2             always 00
//  s_rvalid/s_rready    out/in  1     R handshake
//  rou_stage      out  STAGE_W       target stage of current strobe
//  rou_addr       out  ENTRY_ADDR_W  ROU buffer word address
//  rou_we         out  WE_W          one-hot half-column write enable
//  rou_din        out  DATA_W        half-column data
// BEHAVIOUR
//  Address map: awaddr[1:0] byte offset, [2+:HALF_W] half index h,
//   [2+HALF_W+:ENTRY_ADDR_W] entry, next STAGE_W bits stage; bits above are ignored.
//  Reset (rstn=0, async): every output is 0, including all ready/valid, rou_we and s_rdata.
//   wr_cnt is cleared. An in-flight transaction is dropped: no strobe, no response.
//  Write FSM:
//   IDLE:
//    - awready=1 until AW is latched; wready=1 until W is latched.
//    - AW and W are accepted in either order or in the same cycle.
//    - Once both are latched -> WRITE.
//   WRITE (1 cycle):
//    - If legal: rou_we=1<<h, with rou_addr/rou_stage/rou_din valid; wr_cnt increments.
//    - bvalid=1, bresp set.
//    - -> RESP.
//   RESP:
//    - Hold bvalid and bresp until bready; awready=wready=0.
//    - On bready -> IDLE.
//  Latency: both handshakes complete by cycle T -> rou_we pulse and bvalid at T+1.
//   Minimum spacing between writes is 3 cycles.
//  Legal write: stage<STAGE_NUM && wstrb==4'hF && awaddr[1:0]==0.
//   Any other write -> SLVERR, rou_we stays 0, wr_cnt unchanged.
//  rou_we is 0 in every cycle except the WRITE cycle of a legal write.
//   rou_addr/rou_stage/rou_din hold their last value (don't-care when rou_we=0).
//  Read path, independent of the write FSM:
//   - arready=!rvalid.
//   - On AR handshake at T: rvalid=1 at T+1, rdata=wr_cnt sampled at T, rresp=00.
//   - Hold until rready.
//  wr_cnt: 32-bit, wraps 0xFFFFFFFF->0. Simultaneous read and write: read returns the pre-increment value.
// TESTING
//  - AW/W same cycle: addr=0x0000_0048, data=0xDEAD_BEEF -> T+1: rou_we=0x0004, rou_addr=1, stage=0, din=DEADBEEF, bresp=00.
//  - W 3 cycles before AW: stage 5, entry 7, h 15 -> a single strobe with rou_we=0x8000, rou_stage=5, rou_addr=7.
//  - Stage 12 or wstrb=4'h3 -> bresp=10, no rou_we pulse, counter unchanged.
//  - bready held low 10 cycles -> bvalid stable, awready/wready=0 throughout, no second strobe.
//  - 1000 random legal writes then AR -> rdata=1000. Preload wr_cnt to 0xFFFFFFFF -> wraps to 0.
//  - rstn low in the cycle after both handshakes -> no rou_we, no bvalid; a clean write afterwards gets OKAY.

Source files
------------

// File: rtl/rou_axil_loader.sv
// AXI-Lite write slave that loads the per-stage root-of-unity tables.
// Each host write is decoded into {stage, entry, half-column} and emitted as a
// one-cycle strobe that every per-stage ROU buffer sees; buffers qualify it
// with rou_stage. Reads return a count of accepted (legal) table writes.
module rou_axil_loader #(
    parameter int STAGE_NUM    = 12,
    parameter int STAGE_W      = 4,
    parameter int ENTRY_ADDR_W = 11,
    parameter int WE_W         = 16,
    parameter int DATA_W       = 32
) (
    input  logic                    clk,
    input  logic                    rstn,
    // write address
    input  logic [31:0]             s_awaddr,
    input  logic                    s_awvalid,
    output logic                    s_awready,
    // write data
    input  logic [DATA_W-1:0]       s_wdata,
    input  logic [3:0]              s_wstrb,
    input  logic                    s_wvalid,
    output logic                    s_wready,
    // write response
    output logic [1:0]              s_bresp,
    output logic                    s_bvalid,
    input  logic                    s_bready,
    // read address
    input  logic [31:0]             s_araddr,
    input  logic                    s_arvalid,
    output logic                    s_arready,
    // read data
    output logic [DATA_W-1:0]       s_rdata,
    output logic [1:0]              s_rresp,
    output logic                    s_rvalid,
    input  logic                    s_rready,
    // ROU buffer write strobe
    output logic [STAGE_W-1:0]      rou_stage,
    output logic [ENTRY_ADDR_W-1:0] rou_addr,
    output logic [WE_W-1:0]         rou_we,
    output logic [DATA_W-1:0]       rou_din
);

    localparam int HALF_W    = $clog2(WE_W);
    localparam int ENTRY_LSB = 2 + HALF_W;
    localparam int STAGE_LSB = ENTRY_LSB + ENTRY_ADDR_W;
    localparam int ADDR_USED = STAGE_LSB + STAGE_W;
    localparam logic [STAGE_W:0] STAGE_LIM = STAGE_NUM[STAGE_W:0];
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {IDLE, WRITE, RESP} state_t;

    state_t                  state_q, state_d;
    logic                    en_q;        // holds all readies low until the first cycle out of reset
    logic                    aw_got_q, w_got_q;
    logic                    b_done_q;    // B already handshaken in the WRITE cycle
    logic [1:0]              off_q;
    logic [HALF_W-1:0]       half_q;
    logic [ENTRY_ADDR_W-1:0] entry_q;
    logic [STAGE_W-1:0]      stage_q;
    logic [DATA_W-1:0]       wdata_q;
    logic [3:0]              wstrb_q;
    logic [31:0]             wr_cnt;
    logic                    rvalid_q;
    logic [DATA_W-1:0]       rdata_q;

    logic aw_open, w_open, aw_hs, w_hs, ar_hs;
    logic legal, cnt_inc;
    logic [WE_W-1:0] we_onehot;

    // Upper address bits and the read address carry no information.
    logic unused_bits;
    assign unused_bits = (^s_araddr) ^ (^s_awaddr[31:ADDR_USED]);

    assign aw_open = en_q && (state_q == IDLE) && !aw_got_q;
    assign w_open  = en_q && (state_q == IDLE) && !w_got_q;
    assign aw_hs   = s_awvalid && aw_open;
    assign w_hs    = s_wvalid && w_open;
    assign ar_hs   = s_arvalid && s_arready;

    assign s_awready = aw_open;
    assign s_wready  = w_open;
    assign s_arready = en_q && !rvalid_q;
    assign s_rvalid  = rvalid_q;
    assign s_rdata   = rdata_q;
    assign s_rresp   = RESP_OKAY;

    assign legal     = ({1'b0, stage_q} < STAGE_LIM) && (wstrb_q == 4'hF) && (off_q == 2'b00);
    assign we_onehot = WE_W'(1) << half_q;

    // Strobe payload comes straight from the latched request; it only matters while rou_we is set.
    assign rou_stage = stage_q;
    assign rou_addr  = entry_q;
    assign rou_din   = wdata_q;

    // Write FSM state register and the ready-enable flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            en_q     <= 1'b0;
            b_done_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            en_q     <= 1'b1;
            b_done_q <= (state_q == WRITE) && s_bready;
        end
    end

    // Next state plus the WRITE-cycle strobe and B channel.
    always_comb begin
        state_d  = state_q;
        rou_we   = '0;
        s_bvalid = 1'b0;
        s_bresp  = RESP_OKAY;
        cnt_inc  = 1'b0;
        case (state_q)
            IDLE: begin
                if ((aw_got_q || aw_hs) && (w_got_q || w_hs))
                    state_d = WRITE;
            end
            WRITE: begin
                s_bvalid = 1'b1;
                s_bresp  = legal ? RESP_OKAY : RESP_SLVERR;
                cnt_inc  = legal;
                if (legal)
                    rou_we = we_onehot;
                state_d = RESP;
            end
            RESP: begin
                // A response taken during WRITE must not be offered twice.
                s_bvalid = !b_done_q;
                s_bresp  = (legal && !b_done_q) ? RESP_OKAY :
                           (b_done_q ? RESP_OKAY : RESP_SLVERR);
                if (b_done_q || s_bready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Latch AW and W independently; both flags drop as the write is issued.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            aw_got_q <= 1'b0;
            w_got_q  <= 1'b0;
            off_q    <= '0;
            half_q   <= '0;
            entry_q  <= '0;
            stage_q  <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
        end else begin
            if (aw_hs) begin
                aw_got_q <= 1'b1;
                off_q    <= s_awaddr[1:0];
                half_q   <= s_awaddr[2 +: HALF_W];
                entry_q  <= s_awaddr[ENTRY_LSB +: ENTRY_ADDR_W];
                stage_q  <= s_awaddr[STAGE_LSB +: STAGE_W];
            end else if (state_q == WRITE) begin
                aw_got_q <= 1'b0;
            end
            if (w_hs) begin
                w_got_q <= 1'b1;
                wdata_q <= s_wdata;
                wstrb_q <= s_wstrb;
            end else if (state_q == WRITE) begin
                w_got_q <= 1'b0;
            end
        end
    end

    // Count legal table writes; wraps naturally at 2**32.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            wr_cnt <= '0;
        else if (cnt_inc)
            wr_cnt <= wr_cnt + 32'd1;
    end

    // Read channel: snapshot the pre-increment counter on AR and hold until R is taken.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= DATA_W'(wr_cnt);
        end else if (rvalid_q && s_rready) begin
            rvalid_q <= 1'b0;
        end
    end

endmodule
